// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants and state type for the config frame loader
// CFG_CHECKSUM_EN adds the CHK state to the state enum.
package cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CSUM_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
`ifdef CFG_CHECKSUM_EN
    CHK,
`endif
    STROBE,
    HOLD
  } state_t;

endpackage

// File: rtl/cfg_frame_loader.sv
// rtl/cfg_frame_loader.sv - byte-stream loader that fills one config latch frame and strobes its enable
// CFG_CHECKSUM_EN: when defined, each frame is followed by an XOR checksum byte that must match.
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int FRAME_BITS = 32,
  parameter int NUM_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [NUM_FRAMES-1:0] frame_en,
  output logic                  busy,
  output logic                  err
);

  localparam int NBYTES = FRAME_BITS / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [NUM_FRAMES-1:0] EN_ONE = NUM_FRAMES'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      addr;
  logic            fire;
`ifdef CFG_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
`endif

  assign fire = in_valid & in_ready;

  // All outputs are registered; frame_en drives latch enables and must not glitch.
  always_ff @(posedge clk) begin
    if (!rn) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      frame_en   <= '0;
      frame_data <= '0;
      cnt        <= '0;
      addr       <= '0;
`ifdef CFG_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      frame_en <= '0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (fire && in_data == SYNC_BYTE) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          if (fire) begin
            addr <= in_data;
            cnt  <= '0;
`ifdef CFG_CHECKSUM_EN
            csum <= in_data;
`endif
            if ({24'd0, in_data} >= NUM_FRAMES) begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (fire) begin
            frame_data[{cnt, 3'b000} +: 8] <= in_data;
`ifdef CFG_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (cnt == CW'(NBYTES - 1)) begin
`ifdef CFG_CHECKSUM_EN
              state <= CHK;
`else
              state    <= STROBE;
              frame_en <= EN_ONE << addr;
              in_ready <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef CFG_CHECKSUM_EN
        CHK: begin
          if (fire) begin
            if (in_data == csum) begin
              state    <= STROBE;
              frame_en <= EN_ONE << addr;
              in_ready <= 1'b0;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
`endif
        STROBE: begin
          state <= HOLD;
        end
        HOLD: begin
          // frame_data is still held here to give the latches hold margin.
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
